// File: rtl/mdu_if.sv
// Execute-stage side of the multiply/divide unit: launch, move-to-HI/LO, cancel
// inputs and busy/stall/done/HI/LO results.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_data;
  logic             cancel;
  logic             busy;
  logic             stall_out;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, mt_hi, mt_lo, mt_data, cancel,
    input  busy, stall_out, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, mt_hi, mt_lo, mt_data, cancel,
    output busy, stall_out, done, hi, lo
  );
endinterface

// File: rtl/mdu_pipe.sv
// Multi-cycle multiply / divide / multiply-accumulate unit with HI/LO registers.
// One op in flight; fixed per-class latency; cancel discards the op with no commit.
module mdu_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset_n,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               accept_s;
  logic               commit_s;
  logic               mt_ok_s;
  logic [CW-1:0]      counter_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH-1:0]   q_mag_s;
  logic [WIDTH-1:0]   r_mag_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [2*WIDTH-1:0] result_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: launch, countdown commit, cancel (cancel beats start and commit)
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) begin
          accept_s     = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.cancel) begin
          state_next_s = ST_IDLE;
        end else if (counter_r == CW'(1)) begin
          commit_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Latency counter and latched operands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_r <= {CW{1'b0}};
      op_r      <= 3'b000;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      counter_r <= (bus.op[2:1] == 2'b01) ? DIV_LOAD : MULT_LOAD;
      op_r      <= bus.op;
      a_r       <= bus.src_a;
      b_r       <= bus.src_b;
    end else if (state_r == ST_RUN) begin
      counter_r <= bus.cancel ? {CW{1'b0}} : (counter_r - CW'(1));
    end else begin
      counter_r <= counter_r;
    end
  end

  // Result datapath; op_r[0] selects unsigned, signed division works on magnitudes
  always_comb begin
    ext_a_s  = {{WIDTH{a_r[WIDTH-1] & ~op_r[0]}}, a_r};
    ext_b_s  = {{WIDTH{b_r[WIDTH-1] & ~op_r[0]}}, b_r};
    prod_s   = ext_a_s * ext_b_s;
    neg_a_s  = a_r[WIDTH-1] & ~op_r[0];
    neg_b_s  = b_r[WIDTH-1] & ~op_r[0];
    mag_a_s  = neg_a_s ? (-a_r) : a_r;
    mag_b_s  = neg_b_s ? (-b_r) : b_r;
    q_mag_s  = (b_r == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (mag_a_s / mag_b_s);
    r_mag_s  = (b_r == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (mag_a_s % mag_b_s);
    quot_s   = (neg_a_s ^ neg_b_s) ? (-q_mag_s) : q_mag_s;
    rem_s    = neg_a_s ? (-r_mag_s) : r_mag_s;
    result_s = {hi_r, lo_r};
    case (op_r)
      3'b000, 3'b001: result_s = prod_s;
      3'b010, 3'b011: begin
        if (b_r == {WIDTH{1'b0}}) begin
          result_s = {a_r, {WIDTH{1'b1}}};
        end else begin
          result_s = {rem_s, quot_s};
        end
      end
      3'b100, 3'b101: result_s = {hi_r, lo_r} + prod_s;
      3'b110, 3'b111: result_s = {hi_r, lo_r} - prod_s;
      default:        result_s = {hi_r, lo_r};
    endcase
  end

  assign mt_ok_s = (state_r == ST_IDLE) && !bus.start;

  // HI/LO registers: op commit or idle move-to writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (commit_s) begin
      hi_r <= result_s[2*WIDTH-1:WIDTH];
      lo_r <= result_s[WIDTH-1:0];
    end else if (mt_ok_s) begin
      hi_r <= bus.mt_hi ? bus.mt_data : hi_r;
      lo_r <= bus.mt_lo ? bus.mt_data : lo_r;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_RUN);
      done_r <= commit_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.stall_out = bus.start | busy_r;

endmodule

// File: tb/tb_mdu_pipe.sv
// Directed + random scoreboard bench for mdu_pipe (32-bit build plus a 16-bit build).
module tb_mdu_pipe;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mdu_if #(.WIDTH(32)) bus ();
  mdu_if #(.WIDTH(16)) bus16 ();

  mdu_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  mdu_pipe #(.WIDTH(16), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result built from language-level signed/unsigned arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint sa = longint'($signed(a));
    longint sb_ = longint'($signed(b));
    logic [63:0] sp = 64'(sa * sb_);
    logic [63:0] up = {32'h0, a} * {32'h0, b};
    longint q;
    longint r;
    logic [63:0] res;
    case (o)
      3'd0: res = sp;
      3'd1: res = up;
      3'd2: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb_;
          r = sa % sb_;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      3'd4: res = hl + sp;
      3'd5: res = hl + up;
      3'd6: res = hl - sp;
      default: res = hl - up;
    endcase
    return res;
  endfunction

  function automatic int lat(input logic [2:0] o);
    return (o[2:1] == 2'b01) ? 10 : 5;
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
    logic [63:0] e;
    if (push) begin
      e = model(o, a, b, {m_hi, m_lo});
      sb.push_back(e);
      {m_hi, m_lo} = e;
    end
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    #1 chk("stall_on_start", 64'(bus.stall_out), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int cyc, input bit b2b);
    int n = 0;
    logic [63:0] e;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(cyc));
    chk("done_pulse", 64'(bus.done), 64'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = ~{bus.hi, bus.lo};
    chk("hi", 64'(bus.hi), 64'(e[63:32]));
    chk("lo", 64'(bus.lo), 64'(e[31:0]));
    if (!b2b) begin
      @(negedge clk);
      chk("done_single", 64'(bus.done), 64'd0);
    end
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
    bus.mt_hi = wh; bus.mt_lo = wl; bus.mt_data = d;
    @(negedge clk);
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk("mt_hi", 64'(bus.hi), 64'(m_hi));
    chk("mt_lo", 64'(bus.lo), 64'(m_lo));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    bus.start = 1'b0; bus.op = 3'd0; bus.src_a = 32'h0; bus.src_b = 32'h0;
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0; bus.mt_data = 32'h0; bus.cancel = 1'b0;
    bus16.start = 1'b0; bus16.op = 3'd0; bus16.src_a = 16'h0; bus16.src_b = 16'h0;
    bus16.mt_hi = 1'b0; bus16.mt_lo = 1'b0; bus16.mt_data = 16'h0; bus16.cancel = 1'b0;

    // Reset with non-start inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mt_hi = i[0]; bus.mt_lo = ~i[0]; bus.mt_data = 32'h1234_0000 + 32'(i);
      bus.cancel = i[1]; bus.src_a = $urandom; bus.src_b = $urandom;
      #1;
      chk("rst_hilo", {bus.hi, bus.lo}, 64'h0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_stall", 64'(bus.stall_out), 64'd0);
    end
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    launch(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("mult_expect_hi", 64'(m_hi), 64'hFFFF_FFFF);
    chk("mult_expect_lo", 64'(m_lo), 64'hFFFF_FFF1);
    wait_done(5, 1'b0);

    launch(3'd3, 32'd100, 32'd7, 1'b1);
    wait_done(10, 1'b0);
    chk("divu_lo", 64'(bus.lo), 64'd14);
    chk("divu_hi", 64'(bus.hi), 64'd2);
    launch(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(10, 1'b0);
    chk("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(10, 1'b0);
    chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(bus.hi), 64'h0);
    launch(3'd3, 32'h1234, 32'h0, 1'b1);
    wait_done(10, 1'b0);
    chk("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(bus.hi), 64'h1234);
    launch(3'd2, 32'hFFFF_FF00, 32'h0, 1'b1);
    wait_done(10, 1'b0);

    mt_write(1'b1, 1'b0, 32'hABCD);
    chk("mthi_lo_kept", 64'(bus.lo), 64'hFFFF_FFFF);
    mt_write(1'b1, 1'b1, 32'h0);
    mt_write(1'b0, 1'b1, 32'd3);
    launch(3'd4, 32'd2, 32'd4, 1'b1);
    wait_done(5, 1'b0);
    chk("madd", {bus.hi, bus.lo}, 64'd11);
    launch(3'd6, 32'd3, 32'd4, 1'b1);
    wait_done(5, 1'b0);
    chk("msub", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Cancel in busy cycle 3
    launch(3'd0, 32'd7, 32'd9, 1'b0);
    repeat (2) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk_quiet("cancel_mid");
    @(negedge clk);
    chk("cancel_no_done", 64'(bus.done), 64'd0);

    // Cancel on the commit edge
    launch(3'd1, 32'd7, 32'd9, 1'b0);
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk_quiet("cancel_commit");

    // Start with cancel is ignored; mt with start is ignored
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'd1;
    bus.mt_lo = 1'b1; bus.mt_data = 32'h5555;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0; bus.mt_lo = 1'b0;
    chk_quiet("start_cancel");

    // Start while busy is ignored
    launch(3'd3, 32'd1000, 32'd3, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd1; bus.src_b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(8, 1'b0);

    // Back-to-back launch in the done cycle
    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(5, 1'b1);
    launch(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_done(5, 1'b0);

    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i == 5) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 4 == 1) a = -a;
      launch(o, a, b, 1'b1);
      wait_done(lat(o), 1'b0);
    end

    // Reset mid-operation discards the op immediately
    launch(3'd2, 32'd77, 32'd5, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    m_hi = 32'h0; m_lo = 32'h0;
    chk_quiet("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 16-bit build
    bus16.start = 1'b1; bus16.op = 3'd1; bus16.src_a = 16'hFFFF; bus16.src_b = 16'hFFFF;
    @(negedge clk);
    bus16.start = 1'b0;
    n = 0;
    while (bus16.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("w16_busy_cycles", 64'(n), 64'd5);
    chk("w16_done", 64'(bus16.done), 64'd1);
    chk("w16_hi", 64'(bus16.hi), 64'hFFFE);
    chk("w16_lo", 64'(bus16.lo), 64'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
